// File: rtl/fp16_to_int_seq.sv
// fp16_to_int_seq: iterative fp16 to signed integer converter (RNE, saturating); FP2I_RTZ_EN adds in_rtz truncate mode
module fp16_to_int_seq #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
`ifdef FP2I_RTZ_EN
  input  logic             in_rtz,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_flags
);
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_e;
  localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [32:0] MAX_M = 33'((64'd1 << (OUT_W-1)) - 64'd1);
  state_e           state_q;
  logic             sign_q, left_q, guard_q, sticky_q, rtz_q, out_valid_q;
  logic [16:0]      mag_q;
  logic [3:0]       cnt_q;
  logic [OUT_W-1:0] out_data_q;
  logic [2:0]       out_flags_q;
  logic             rtz_d;
  logic [4:0]       exp_w, pe_w, rsh_w;
  logic             left_w, nan_w, inf_w, zero_w;
  logic [3:0]       n_w;
  logic             inc_w, ovf_w;
  logic [17:0]      rmag_w;
  logic [OUT_W-1:0] rval_w, data_d;
  logic [2:0]       flags_d;
`ifdef FP2I_RTZ_EN
  assign rtz_d = in_rtz;
`else
  assign rtz_d = 1'b0;
`endif
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;
  // classify the incoming operand and derive the shift direction and count
  always_comb begin
    exp_w  = in_data[14:10];
    pe_w   = (exp_w == 5'd0) ? 5'd1 : exp_w;
    left_w = pe_w >= 5'd25;
    rsh_w  = 5'd25 - pe_w;
    n_w    = left_w ? 4'(pe_w - 5'd25) : (rsh_w > 5'd12 ? 4'd12 : rsh_w[3:0]);
    nan_w  = (&exp_w) & (|in_data[9:0]);
    inf_w  = (&exp_w) & ~(|in_data[9:0]);
    zero_w = ~(|in_data[14:0]);
  end
  // round to nearest even (or truncate), apply sign and saturate to the output range
  always_comb begin
    inc_w   = ~rtz_q & guard_q & (sticky_q | mag_q[0]);
    rmag_w  = {1'b0, mag_q} + 18'(inc_w);
    ovf_w   = 33'(rmag_w) > (sign_q ? MAX_M + 33'd1 : MAX_M);
    rval_w  = OUT_W'(rmag_w);
    data_d  = ovf_w ? (sign_q ? MIN_V : MAX_V) : (sign_q ? -rval_w : rval_w);
    flags_d = {1'b0, ovf_w, guard_q | sticky_q};
  end
  // control FSM: accept/classify, shift one bit per cycle, round, hold result until drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      left_q      <= 1'b0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      rtz_q       <= 1'b0;
      mag_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sign_q   <= in_data[15];
          left_q   <= left_w;
          guard_q  <= 1'b0;
          sticky_q <= 1'b0;
          rtz_q    <= rtz_d;
          mag_q    <= {6'd0, |exp_w, in_data[9:0]};
          cnt_q    <= n_w;
          if (nan_w | inf_w | zero_w) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= inf_w ? (in_data[15] ? MIN_V : MAX_V) : '0;
            out_flags_q <= {nan_w, inf_w, 1'b0};
          end else begin
            state_q <= (n_w == 4'd0) ? ROUND : SHIFT;
          end
        end
        SHIFT: begin
          mag_q    <= left_q ? {mag_q[15:0], 1'b0} : {1'b0, mag_q[16:1]};
          guard_q  <= left_q ? 1'b0 : mag_q[0];
          sticky_q <= sticky_q | guard_q;
          cnt_q    <= cnt_q - 4'd1;
          state_q  <= (cnt_q == 4'd1) ? ROUND : SHIFT;
        end
        ROUND: begin
          out_data_q  <= data_d;
          out_flags_q <= flags_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        default: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end
endmodule
